// File: rtl/traffic_phase_scheduler.sv
// Demand-driven four-way phase scheduler: round-robin green grants with GREEN -> YELLOW -> ALL-RED
// sequencing, emergency pre-emption, and timing that advances only on an external tick strobe.
module traffic_phase_scheduler #(
  parameter int GREEN_SEC  = 5,
  parameter int YELLOW_SEC = 1,
  parameter int ALLRED_SEC = 1,
  parameter int TW         = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic [3:0] req,
  input  logic       emerg_req,
  input  logic [1:0] emerg_dir,
  output logic [1:0] north,
  output logic [1:0] east,
  output logic [1:0] south,
  output logic [1:0] west,
  output logic [1:0] green_dir,
  output logic [3:0] pending,
  output logic       emerg_ack
);

  typedef enum logic [1:0] {
    S_ALLRED = 2'd0,
    S_GREEN  = 2'd1,
    S_YELLOW = 2'd2
  } state_t;

  localparam logic [TW-1:0] G_LAST = TW'(GREEN_SEC - 1);
  localparam logic [TW-1:0] Y_LAST = TW'(YELLOW_SEC - 1);
  localparam logic [TW-1:0] A_LAST = TW'(ALLRED_SEC - 1);
  localparam logic [TW-1:0] A_DONE = TW'(ALLRED_SEC);

  state_t        state;
  logic [TW-1:0] cnt;
  logic [7:0]    lights;
  logic [3:0]    req_eff;
  logic          sel_valid;
  logic [1:0]    sel_dir;
  logic          allred_expired;

  // Direction 0 (N) maps to req/pending bit 3, direction 3 (W) to bit 0.
  function automatic logic [3:0] dir_bit(input logic [1:0] d);
    return 4'b1000 >> d;
  endfunction

  function automatic logic [7:0] lamp(input state_t s, input logic [1:0] d);
    logic [7:0] l;
    l = 8'h00;
    if (s == S_GREEN)  l = 8'b1000_0000 >> {d, 1'b0};
    if (s == S_YELLOW) l = 8'b0100_0000 >> {d, 1'b0};
    return l;
  endfunction

  assign {north, east, south, west} = lights;

  // The approach being served absorbs its own new demand.
  always_comb begin
    req_eff = req;
    if (state == S_GREEN || state == S_YELLOW) req_eff = req & ~dir_bit(green_dir);
  end

  // Idle ALLRED parks the counter at A_DONE so a late request is granted on the next edge.
  assign allred_expired = (cnt == A_DONE) || (tick && cnt == A_LAST);

  always_comb begin
    sel_valid = 1'b0;
    sel_dir   = green_dir;
    if (emerg_req) begin
      sel_valid = 1'b1;
      sel_dir   = emerg_dir;
    end else begin
      for (int k = 1; k <= 4; k++) begin
        if (!sel_valid && (pending & dir_bit(green_dir + 2'(k))) != 4'b0000) begin
          sel_valid = 1'b1;
          sel_dir   = green_dir + 2'(k);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_ALLRED;
      cnt       <= '0;
      green_dir <= 2'd3;
      pending   <= 4'b0000;
      lights    <= 8'h00;
      emerg_ack <= 1'b0;
    end else begin
      pending <= pending | req_eff;
      case (state)
        S_ALLRED: begin
          if (allred_expired) begin
            if (sel_valid) begin
              state     <= S_GREEN;
              cnt       <= '0;
              green_dir <= sel_dir;
              pending   <= (pending | req_eff) & ~dir_bit(sel_dir);
              lights    <= lamp(S_GREEN, sel_dir);
              // An emergency request always selects its own direction here.
              emerg_ack <= emerg_req;
            end else begin
              cnt <= A_DONE;
            end
          end else if (tick) begin
            cnt <= cnt + 1'b1;
          end
        end
        S_GREEN: begin
          if (emerg_req && emerg_dir != green_dir) begin
            state     <= S_YELLOW;
            cnt       <= '0;
            lights    <= lamp(S_YELLOW, green_dir);
            emerg_ack <= 1'b0;
          end else if (emerg_req) begin
            cnt       <= '0;
            emerg_ack <= 1'b1;
          end else begin
            emerg_ack <= 1'b0;
            if (tick) begin
              if (cnt == G_LAST) begin
                state  <= S_YELLOW;
                cnt    <= '0;
                lights <= lamp(S_YELLOW, green_dir);
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
        end
        S_YELLOW: begin
          if (tick) begin
            if (cnt == Y_LAST) begin
              state  <= S_ALLRED;
              cnt    <= '0;
              lights <= 8'h00;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          state  <= S_ALLRED;
          cnt    <= '0;
          lights <= 8'h00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Scoreboard bench for traffic_phase_scheduler: expected light snapshots (with tick durations)
// and pending probes are queued by the driver and checked by separate monitor processes.
module tb_traffic_phase_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick;
  logic [3:0] req;
  logic       emerg_req;
  logic [1:0] emerg_dir;
  logic [1:0] north, east, south, west;
  logic [1:0] green_dir;
  logic [3:0] pending;
  logic       emerg_ack;

  traffic_phase_scheduler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick      (tick),
    .req       (req),
    .emerg_req (emerg_req),
    .emerg_dir (emerg_dir),
    .north     (north),
    .east      (east),
    .south     (south),
    .west      (west),
    .green_dir (green_dir),
    .pending   (pending),
    .emerg_ack (emerg_ack)
  );

  // Clock / tick / reset-time defaults
  always #5 clk = ~clk;

  initial begin
    tick = 1'b0;
    forever begin
      repeat (3) @(posedge clk);
      #1 tick = 1'b1;
      @(posedge clk);
      #1 tick = 1'b0;
    end
  end

  int tick_cnt = 0;
  always @(posedge clk) if (tick === 1'b1) tick_cnt <= tick_cnt + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, total=%0d", total);
    $fatal(1, "watchdog");
  end

  // Scoreboard state: snapshot = {north,east,south,west,green_dir,emerg_ack}
  int          total = 0;
  int          bad   = 0;
  logic [10:0] exp_q[$];
  int          exp_dt_q[$];
  logic [3:0]  pend_q[$];
  logic [10:0] snap;
  logic        mon_en    = 1'b0;
  logic        have_last = 1'b0;
  logic [10:0] last_snap;
  int          last_tick = 0;
  logic [10:0] mon_e;
  int          mon_edt;
  int          mon_dt;
  int          nonred;
  logic        bad_code;
  logic [7:0]  mon_lt;
  logic [3:0]  pend_e;
  event        probe_ev;

  assign snap = {north, east, south, west, green_dir, emerg_ack};

  // Light monitor: every visible output change pops one expected snapshot.
  always @(negedge clk) begin
    if (mon_en && (!have_last || snap !== last_snap)) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_change: got=%b with no expectation at tick %0d", snap, tick_cnt);
      end else begin
        mon_e   = exp_q.pop_front();
        mon_edt = exp_dt_q.pop_front();
        mon_dt  = tick_cnt - last_tick;
        total++;
        if (snap !== mon_e) begin
          bad++;
          $display("FAIL snapshot: got=%b exp=%b at tick %0d", snap, mon_e, tick_cnt);
        end
        if (mon_edt >= 0 && have_last) begin
          total++;
          if (mon_dt != mon_edt) begin
            bad++;
            $display("FAIL duration: got=%0d ticks exp=%0d ticks before %b", mon_dt, mon_edt, mon_e);
          end
        end
      end
      mon_lt   = snap[10:3];
      nonred   = 0;
      bad_code = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (mon_lt[2*i +: 2] != 2'b00) nonred++;
        if (mon_lt[2*i +: 2] == 2'b11) bad_code = 1'b1;
      end
      total++;
      if (nonred > 1 || bad_code) begin
        bad++;
        $display("FAIL one_light: got lights=%b exp at most one non-red legal code", mon_lt);
      end
      last_snap = snap;
      last_tick = tick_cnt;
      have_last = 1'b1;
    end
  end

  // Pending monitor: each probe is checked on the following falling edge.
  always begin
    @(probe_ev);
    @(negedge clk);
    pend_e = pend_q.pop_front();
    total++;
    if (pending !== pend_e) begin
      bad++;
      $display("FAIL pending: got=%b exp=%b at tick %0d", pending, pend_e, tick_cnt);
    end
  end

  // Driver tasks
  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      do @(posedge clk); while (tick !== 1'b1);
    end
    #1;
  endtask

  task automatic push_exp(input logic [7:0] lt, input logic [1:0] gd, input logic ack, input int dt);
    exp_q.push_back({lt, gd, ack});
    exp_dt_q.push_back(dt);
  endtask

  task automatic probe(input logic [3:0] e);
    pend_q.push_back(e);
    -> probe_ev;
  endtask

  localparam logic [7:0] RED = 8'h00;
  localparam logic [7:0] NG = 8'b10_00_00_00, NY = 8'b01_00_00_00;
  localparam logic [7:0] EG = 8'b00_10_00_00, EY = 8'b00_01_00_00;
  localparam logic [7:0] SG = 8'b00_00_10_00, SY = 8'b00_00_01_00;
  localparam logic [7:0] WG = 8'b00_00_00_10, WY = 8'b00_00_00_01;

  initial begin
    rst_n = 1'b0; req = 4'b0000; emerg_req = 1'b0; emerg_dir = 2'd0;

    // Reset, then 20 ticks of all-red with no demand
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    push_exp(RED, 2'd3, 1'b0, -1);
    mon_en = 1'b1;
    probe(4'b0000);
    wait_ticks(20);

    // Single east request
    push_exp(EG,  2'd1, 1'b0, -1);
    push_exp(EY,  2'd1, 1'b0, 5);
    push_exp(RED, 2'd1, 1'b0, 1);
    req = 4'b0100;
    @(posedge clk);
    #1 req = 4'b0000;
    wait_ticks(8);
    probe(4'b0000);

    // Reset, then all approaches demanding: N,E,S,W,N
    push_exp(RED, 2'd3, 1'b0, -1);
    push_exp(NG,  2'd0, 1'b0, -1);
    push_exp(NY,  2'd0, 1'b0, 5);
    push_exp(RED, 2'd0, 1'b0, 1);
    push_exp(EG,  2'd1, 1'b0, 1);
    push_exp(EY,  2'd1, 1'b0, 5);
    push_exp(RED, 2'd1, 1'b0, 1);
    push_exp(SG,  2'd2, 1'b0, 1);
    push_exp(SY,  2'd2, 1'b0, 5);
    push_exp(RED, 2'd2, 1'b0, 1);
    push_exp(WG,  2'd3, 1'b0, 1);
    push_exp(WY,  2'd3, 1'b0, 5);
    push_exp(RED, 2'd3, 1'b0, 1);
    push_exp(NG,  2'd0, 1'b0, 1);
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    req = 4'b1111;
    wait_ticks(29);
    req = 4'b0000;

    // Emergency for S at tick 2 of N green; pending E,S,W left over from the loop
    push_exp(NY,  2'd0, 1'b0, 2);
    push_exp(RED, 2'd0, 1'b0, 1);
    push_exp(SG,  2'd2, 1'b1, 1);
    push_exp(SG,  2'd2, 1'b0, 3);
    push_exp(SY,  2'd2, 1'b0, 5);
    push_exp(RED, 2'd2, 1'b0, 1);
    push_exp(WG,  2'd3, 1'b0, 1);
    push_exp(WY,  2'd3, 1'b0, 5);
    push_exp(RED, 2'd3, 1'b0, 1);
    push_exp(EG,  2'd1, 1'b0, 1);
    push_exp(RED, 2'd3, 1'b0, 2);
    wait_ticks(2);
    emerg_req = 1'b1;
    emerg_dir = 2'd2;
    wait_ticks(5);
    emerg_req = 1'b0;

    // W request held through W green and yellow is absorbed; E is served next
    wait_ticks(7);
    req = 4'b0001;
    wait_ticks(5);
    probe(4'b0100);
    wait_ticks(1);
    req = 4'b0000;
    wait_ticks(1);

    // Reset in the middle of E green with N and W pending
    req = 4'b1001;
    @(posedge clk);
    #1 req = 4'b0000;
    probe(4'b1001);
    wait_ticks(2);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    probe(4'b0000);
    wait_ticks(6);

    // Final report
    total++;
    if (exp_q.size() != 0 || pend_q.size() != 0) begin
      bad++;
      $display("FAIL leftover: got %0d snapshots and %0d probes unchecked, exp 0", exp_q.size(), pend_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
